arch_reg_dump: RTL and testbench

- Reads architectural register state out of the PRF and streams it to an external debug/checkpoint host over a valid/ready handshake.
- Runs only after register consolidation has completed, when logical register i resides at physical register i for i = 0..NUM_REGS-1.
- Borrows the lane-1 PRF read port (phySrc1 of lane 1) while active and holds the pipeline stalled via dumpFlag_o.
- This is the reader counterpart to consolidation's writeback over the lane-1 bypass.

---
 rtl/arch_reg_dump_pkg.sv | 40 ++++
 rtl/arch_reg_dump_fifo.sv | 58 +++++
 rtl/arch_reg_dump.sv | 129 ++++++++++++
 tb/tb_arch_reg_dump.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arch_reg_dump_pkg.sv
// Shared types and constants for the architectural register dump engine.
// Core-wide sizing macros fall back to these defaults when the build does not define them.
`ifndef SIZE_RMT
`define SIZE_RMT 34
`endif
`ifndef SIZE_RMT_LOG
`define SIZE_RMT_LOG 6
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 4
`endif
`ifndef SRAM_DATA_WIDTH
`define SRAM_DATA_WIDTH 8
`endif

package arch_reg_dump_pkg;

    localparam int unsigned DUMP_LANE = 1;
    localparam int unsigned ADDR_W    = `SIZE_RMT_LOG;
    localparam int unsigned BYTE_W    = `SRAM_DATA_WIDTH;
    localparam int unsigned DATA_W    = 4 * `SRAM_DATA_WIDTH;
    localparam int unsigned PHYS_W    = `SIZE_PHYSICAL_LOG;
    localparam int unsigned ISSUE_W   = `ISSUE_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } dumpState_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } dumpEntry;

endpackage

// File: rtl/arch_reg_dump_fifo.sv
// Small output FIFO holding dumped register entries until the host accepts them.
// Head outputs read as zero while empty so the host port is quiet between dumps.
module dump_fifo
    import arch_reg_dump_pkg::*;
#(
    parameter  int unsigned BUF_DEPTH = 2,
    localparam int unsigned PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  dumpEntry         pushEntry,
    input  logic             pop,
    output dumpEntry         headEntry,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty
);

    dumpEntry         mem [BUF_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (occupancy == '0);
    assign full      = (occupancy == CNT_W'(BUF_DEPTH));
    assign doPop     = pop && !empty;
    assign headEntry = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= pushEntry;
                wrPtr      <= nextPtr(wrPtr);
            end
            if (doPop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            case ({push, doPop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: ;
            endcase
        end
    end

    noOverflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !doPop));

endmodule

// File: rtl/arch_reg_dump.sv
// Streams architectural registers (logical i == physical i after consolidation) to a debug host,
// borrowing one PRF read port while the pipeline is held off by dumpFlag_o.
module arch_reg_dump
    import arch_reg_dump_pkg::*;
#(
    parameter int unsigned NUM_REGS  = `SIZE_RMT,
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned LANE      = DUMP_LANE
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           startDump_i,
    input  logic [`ISSUE_WIDTH-1:0][`SIZE_PHYSICAL_LOG-1:0] phySrc1_i,
    input  logic [`ISSUE_WIDTH-1:0][`SRAM_DATA_WIDTH-1:0]   regVal_byte0_i,
    input  logic [`ISSUE_WIDTH-1:0][`SRAM_DATA_WIDTH-1:0]   regVal_byte1_i,
    input  logic [`ISSUE_WIDTH-1:0][`SRAM_DATA_WIDTH-1:0]   regVal_byte2_i,
    input  logic [`ISSUE_WIDTH-1:0][`SRAM_DATA_WIDTH-1:0]   regVal_byte3_i,
    output logic [`ISSUE_WIDTH-1:0][`SIZE_PHYSICAL_LOG-1:0] phySrc1_rd_o,
    output logic                                           dumpFlag_o,
    output logic                                           dumpValid_o,
    output logic [`SIZE_RMT_LOG-1:0]                       dumpAddr_o,
    output logic [4*`SRAM_DATA_WIDTH-1:0]                  dumpData_o,
    input  logic                                           dumpReady_i,
    output logic                                           doneDump_o
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    dumpState_t        state;
    logic [ADDR_W-1:0] issuePtr;
    logic [ADDR_W-1:0] inflightAddr;
    logic              inflight;
    logic              issue;
    logic              pop;
    logic              drainDone;
    logic [CNT_W:0]    used;
    logic [CNT_W-1:0]  occupancy;
    logic              fifoFull;
    logic              fifoEmpty;
    dumpEntry          pushEntry;
    dumpEntry          headEntry;
    logic              unusedRegVal;

    // Credit counts entries already queued plus the read in flight, before this cycle's pop.
    assign used  = {1'b0, occupancy} + {{CNT_W{1'b0}}, inflight};
    assign issue = (state == READ)
                && (issuePtr < ADDR_W'(NUM_REGS))
                && (used < (CNT_W + 1)'(BUF_DEPTH));

    assign pushEntry = '{addr: inflightAddr,
                         data: {regVal_byte3_i[LANE], regVal_byte2_i[LANE],
                                regVal_byte1_i[LANE], regVal_byte0_i[LANE]}};

    assign dumpValid_o = !fifoEmpty;
    assign dumpAddr_o  = headEntry.addr;
    assign dumpData_o  = headEntry.data;
    assign pop         = dumpValid_o && dumpReady_i;

    // Leave DRAIN on the cycle the final entry is accepted, so done follows the last beat directly.
    assign drainDone = !inflight && (fifoEmpty || ((occupancy == CNT_W'(1)) && pop));

    assign unusedRegVal = ^{regVal_byte0_i, regVal_byte1_i, regVal_byte2_i, regVal_byte3_i};

    always_comb begin
        phySrc1_rd_o = phySrc1_i;
        if (issue) begin
            phySrc1_rd_o[LANE] = `SIZE_PHYSICAL_LOG'(issuePtr);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            issuePtr     <= '0;
            inflight     <= 1'b0;
            inflightAddr <= '0;
            dumpFlag_o   <= 1'b0;
            doneDump_o   <= 1'b0;
        end else begin
            doneDump_o <= 1'b0;
            inflight   <= issue;
            if (issue) begin
                inflightAddr <= issuePtr;
                issuePtr     <= issuePtr + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (startDump_i) begin
                        state      <= READ;
                        issuePtr   <= '0;
                        dumpFlag_o <= 1'b1;
                    end
                end
                READ: begin
                    if (issue && (issuePtr == ADDR_W'(NUM_REGS - 1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drainDone) begin
                        state      <= DONE;
                        dumpFlag_o <= 1'b0;
                        doneDump_o <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dump_fifo #(
        .BUF_DEPTH(BUF_DEPTH)
    ) uFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight),
        .pushEntry(pushEntry),
        .pop      (pop),
        .headEntry(headEntry),
        .occupancy(occupancy),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    fullOnlyWhenAllowed: assert property (@(posedge clk) disable iff (reset)
        fifoFull |-> (occupancy == CNT_W'(BUF_DEPTH)));

endmodule

// File: tb/tb_arch_reg_dump.sv
// Randomized bench for arch_reg_dump against a transaction-level model of issue credit,
// PRF read latency, beat ordering, handshake stalls and dump start/finish.
module tb_arch_reg_dump;
    import arch_reg_dump_pkg::*;

    localparam int unsigned N  = 34;
    localparam int unsigned LN = DUMP_LANE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                              reset;
    logic                              startDump_i;
    logic                              dumpReady_i;
    logic [ISSUE_W-1:0][PHYS_W-1:0]    phySrc1_i;
    logic [ISSUE_W-1:0][PHYS_W-1:0]    phySrc1_rd_o;
    logic [ISSUE_W-1:0][BYTE_W-1:0]    regVal_byte0_i;
    logic [ISSUE_W-1:0][BYTE_W-1:0]    regVal_byte1_i;
    logic [ISSUE_W-1:0][BYTE_W-1:0]    regVal_byte2_i;
    logic [ISSUE_W-1:0][BYTE_W-1:0]    regVal_byte3_i;
    logic                              dumpFlag_o;
    logic                              dumpValid_o;
    logic [ADDR_W-1:0]                 dumpAddr_o;
    logic [DATA_W-1:0]                 dumpData_o;
    logic                              doneDump_o;

    arch_reg_dump #(
        .NUM_REGS (N),
        .BUF_DEPTH(2),
        .LANE     (LN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .startDump_i   (startDump_i),
        .phySrc1_i     (phySrc1_i),
        .regVal_byte0_i(regVal_byte0_i),
        .regVal_byte1_i(regVal_byte1_i),
        .regVal_byte2_i(regVal_byte2_i),
        .regVal_byte3_i(regVal_byte3_i),
        .phySrc1_rd_o  (phySrc1_rd_o),
        .dumpFlag_o    (dumpFlag_o),
        .dumpValid_o   (dumpValid_o),
        .dumpAddr_o    (dumpAddr_o),
        .dumpData_o    (dumpData_o),
        .dumpReady_i   (dumpReady_i),
        .doneDump_o    (doneDump_o)
    );

    // Reference state: the PRF contents and the dump as a sequence of issued/accepted indices.
    logic [DATA_W-1:0]              prf [2**PHYS_W];
    logic [ISSUE_W-1:0][PHYS_W-1:0] rdSeen;
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;
    int unsigned issueCyc [N];
    int unsigned issued = 0;
    int unsigned popped = 0;
    int unsigned doneCount = 0;
    int unsigned beatCount = 0;
    int unsigned obsIssues = 0;
    bit busy = 1'b0;
    bit doneNow = 1'b0;
    bit afterReset = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input bit rdy, input bit st, input bit rst);
        dumpReady_i = rdy;
        startDump_i = st;
        reset       = rst;
        for (int l = 0; l < ISSUE_W; l++) phySrc1_i[l] = PHYS_W'($urandom);
        // Keep the pipeline's own lane address outside 0..N-1 so a borrowed read is unambiguous.
        phySrc1_i[LN] = PHYS_W'($urandom_range(64, 127));
    endtask

    task automatic cycle();
        int unsigned avail;
        bit expIssue, expValid, pop, wasIdle, nextDone;
        @(negedge clk);
        avail = 0;
        for (int k = 0; k < int'(issued); k++) if (issueCyc[k] + 2 <= cyc) avail++;
        expIssue = busy && (issued < N) && ((issued - popped) < 2);
        expValid = busy && (avail > popped);
        chk("dumpFlag", 64'(dumpFlag_o), 64'(busy));
        chk("doneDump", 64'(doneDump_o), 64'(doneNow));
        chk("dumpValid", 64'(dumpValid_o), 64'(expValid));
        if (expValid) begin
            chk("dumpAddr", 64'(dumpAddr_o), 64'(popped));
            chk("dumpData", 64'(dumpData_o), 64'(prf[popped]));
        end
        if (afterReset) begin
            chk("resetAddr", 64'(dumpAddr_o), 64'(0));
            chk("resetData", 64'(dumpData_o), 64'(0));
        end
        for (int l = 0; l < ISSUE_W; l++) begin
            if (l == LN) chk("rdLane1", 64'(phySrc1_rd_o[l]), expIssue ? 64'(issued) : 64'(phySrc1_i[l]));
            else         chk("rdPass", 64'(phySrc1_rd_o[l]), 64'(phySrc1_i[l]));
        end
        if (doneDump_o) doneCount++;
        if (dumpValid_o && dumpReady_i) beatCount++;
        if (phySrc1_rd_o[LN] != phySrc1_i[LN]) obsIssues++;
        rdSeen   = phySrc1_rd_o;
        pop      = expValid && dumpReady_i;
        wasIdle  = !busy && !doneNow;
        nextDone = 1'b0;
        if (expIssue) begin
            issueCyc[issued] = cyc;
            issued++;
        end
        if (pop) begin
            popped++;
            if (popped == N) begin
                busy     = 1'b0;
                nextDone = 1'b1;
            end
        end
        doneNow = nextDone;
        if (startDump_i && wasIdle) begin
            busy   = 1'b1;
            issued = 0;
            popped = 0;
        end
        afterReset = 1'b0;
        if (reset) begin
            busy       = 1'b0;
            doneNow    = 1'b0;
            issued     = 0;
            popped     = 0;
            afterReset = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int l = 0; l < ISSUE_W; l++) begin
            regVal_byte0_i[l] = prf[rdSeen[l]][7:0];
            regVal_byte1_i[l] = prf[rdSeen[l]][15:8];
            regVal_byte2_i[l] = prf[rdSeen[l]][23:16];
            regVal_byte3_i[l] = prf[rdSeen[l]][31:24];
        end
    endtask

    // mode 0: ready high; 1: ready 1,0,0,1 repeating; 2: random; 3: low for 10 cycles then high.
    function automatic bit readyFor(input int unsigned mode, input int unsigned k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 4 == 0) || (k % 4 == 3);
            2:       return 1'($urandom_range(0, 1));
            default: return k >= 10;
        endcase
    endfunction

    task automatic doDump(input int unsigned mode, input int unsigned resetAt, input bit pokeDrain);
        int unsigned k, d0, b0, i0;
        bit didReset, didPoke, st, rst;
        d0 = doneCount;
        b0 = beatCount;
        i0 = obsIssues;
        didReset = 1'b0;
        didPoke  = 1'b0;
        drive(readyFor(mode, 0), 1'b1, 1'b0);
        cycle();
        k = 1;
        while ((busy || doneNow) && k < 600) begin
            st  = 1'b0;
            rst = 1'b0;
            if (pokeDrain && !didPoke && busy && issued == N) begin
                st      = 1'b1;
                didPoke = 1'b1;
            end
            if (resetAt != 0 && !didReset && popped == resetAt) begin
                rst      = 1'b1;
                didReset = 1'b1;
            end
            drive(readyFor(mode, k), st, rst);
            cycle();
            if (mode == 3 && k == 10) chk("stallIssues", 64'(obsIssues - i0), 64'(2));
            k++;
        end
        chk("dumpTimeout", 64'(busy), 64'(0));
        repeat (2) begin
            drive(1'b1, 1'b0, 1'b0);
            cycle();
        end
        if (resetAt != 0) begin
            chk("abortNoDone", 64'(doneCount - d0), 64'(0));
        end else begin
            chk("doneOnce", 64'(doneCount - d0), 64'(1));
            chk("beatTotal", 64'(beatCount - b0), 64'(N));
        end
    endtask

    initial begin
        for (int i = 0; i < 2**PHYS_W; i++) prf[i] = 32'hA500_0000 + 32'(i);
        regVal_byte0_i = '0;
        regVal_byte1_i = '0;
        regVal_byte2_i = '0;
        regVal_byte3_i = '0;
        rdSeen = '0;
        drive(1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        cycle();
        drive(1'b1, 1'b0, 1'b1);
        cycle();

        // Outside a dump the borrowed lane passes the pipeline address straight through.
        repeat (2) begin
            drive(1'b1, 1'b0, 1'b0);
            phySrc1_i[LN] = PHYS_W'(7);
            cycle();
        end

        doDump(0, 0, 1'b0);

        for (int i = 0; i < int'(N); i++) prf[i] = $urandom;
        doDump(1, 0, 1'b0);
        doDump(3, 0, 1'b0);

        doDump(2, 5, 1'b0);
        doDump(0, 0, 1'b0);

        for (int i = 0; i < int'(N); i++) prf[i] = $urandom;
        doDump(2, 0, 1'b1);
        doDump(0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
